spcl_rdback: RTL and testbench
==============================

Name: spcl_rdback

Overview:
- Read-back unit for the special-register file. It returns the value selected by fsel on the core's file-data bus (fout), which the ALU consumes as fin.
- Covers the read direction of the same address map that the special-register writer updates: INDF/FSR indirection, STATUS, FSR, PORTA/B/C with TRIS-qualified pin sampling, and general register-file reads via a req/ack handshake with timeout.
- Sits between the special-register block, the external port pins and the register-file RAM.

Parameters:
- SYNC_STAGES, 2, number of flops in each port-pin synchronizer (minimum 2).
- RF_TIMEOUT, 15, number of cycles waited for rf_ack before aborting (1..255).

Ports:
- clk4  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd_req  input  1  read request; accepted only when busy=0.
- fsel  input  5  file address of the request.
- fsr  input  8  current FSR value; fsr[4:0] is used for indirection.
- status  input  8  current STATUS register value.
- tmr0  input  8  current TMR0 value.
- pcl  input  8  current PC[7:0].
- port_int_a, port_int_b, port_int_c  input  8 each  output-latch values.
- trisa, trisb, trisc  input  8 each  direction bits; 1 = input.
- pin_a, pin_b, pin_c  input  8 each  asynchronous external pin levels.
- rf_rd  output  1  register-file read strobe; held high until ack or timeout.
- rf_addr  output  5  register-file address.
- rf_data  input  8  register-file read data; valid with rf_ack.
- rf_ack  input  1  register-file acknowledge.
- busy  output  1  high from accept until the cycle fout_vld is asserted.
- fout  output  8  read data; held until the next completion.
- fout_vld  output  1  one-cycle pulse marking fout as new.
- rd_err  output  1  high with fout_vld when the read timed out.
- port_chg  output  3  per-port input-change flags; bit 0 = A, bit 1 = B, bit 2 = C.

Behaviour:
- Reset values: fout=0, fout_vld=0, busy=0, rf_rd=0, rf_addr=0, rd_err=0, port_chg=0, all synchronizer flops=0, state=IDLE, timeout counter=0.
- Pin synchronizers:
  - Each pin bit passes through SYNC_STAGES flops; sync_x is the last stage.
  - A pin change reaches sync_x after SYNC_STAGES edges.
- Address resolution at accept:
  - eff = (fsel==0) ? fsr[4:0] : fsel.
  - If eff==0 (indirect through INDF), data = 8'h00 with no error.
- Read map:
  - 1 returns tmr0; 2 returns pcl; 3 returns status; 4 returns fsr.
  - 5/6/7 return a port value per bit: (tris[i] ? sync[i] : port_int[i]).
  - eff>=8 is a register-file read.
- State IDLE:
  - On rd_req with busy=0, eff, tris and sync values are captured.
  - Special address (eff<8): next state DONE, busy=1.
  - Register-file address: next state RF_WAIT, rf_rd=1, rf_addr=eff, counter cleared, busy=1.
- State RF_WAIT:
  - rf_ack=1: capture rf_data and go to DONE with rd_err=0.
  - Otherwise the counter increments. When it reaches RF_TIMEOUT, data=8'hFF, rd_err=1, and the state goes to DONE.
  - rf_rd drops on leaving RF_WAIT.
  - If rf_ack arrives in the same cycle the counter hits RF_TIMEOUT, ack wins.
- State DONE:
  - fout is loaded, fout_vld=1 for one cycle, busy=0, and the state returns to IDLE.
  - rd_err is valid only in the cycle fout_vld=1; otherwise 0.
- Latency:
  - Special read: fout_vld is asserted 2 edges after the rd_req edge.
  - Register-file read: fout_vld is asserted 1 edge after the rf_ack edge.
- rd_req while busy=1 is ignored; there is no queueing.
- rf_ack outside RF_WAIT is ignored.
- Reset asserted mid-transaction aborts immediately to the reset values. No fout_vld is produced.

Optional Feature:
- Macro: SPCL_CHG_DETECT_EN.
- When defined:
  - Each port keeps snapshot registers, loaded with the value returned whenever that port is read.
  - port_chg[k] is a registered flag: it is set when the OR over all bits of ((sync ^ snap) & tris) is 1.
  - The flag clears in the DONE cycle of a read of port k. A difference detected in that same cycle is re-evaluated against the new snapshot on the next edge.
  - Snapshots reset to 0.
- When undefined: port_chg is tied to 3'b000 and no snapshot logic exists.

Test Plan:
- Reset, then rd_req with fsel=3 and status=8'h05 -> fout_vld is asserted 2 edges after the rd_req edge with fout=8'h05 and busy high in between.
- trisa=8'hF0, port_int_a=8'hAA, pin_a=8'h3C, wait SYNC_STAGES+1 edges, read fsel=5 -> fout=8'h3A.
- fsel=0, fsr=8'h12, rf_ack after 3 cycles with rf_data=8'h7E -> rf_addr=5'h12, rf_rd high for 4 cycles, fout=8'h7E, rd_err=0.
- fsel=9 with no rf_ack -> after RF_TIMEOUT=15 cycles fout=8'hFF, rd_err=1, rf_rd=0; a second rd_req issued while busy produces no extra fout_vld.
- rf_ack on the exact timeout cycle -> rf_data is returned with rd_err=0; fsel=0 with fsr=0 -> fout=8'h00.
- With SPCL_CHG_DETECT_EN defined: trisb=8'hFF, read B, toggle pin_b[2] -> port_chg[1]=1 after SYNC_STAGES+1 edges, cleared by the next read of B. Reset asserted while in RF_WAIT -> all outputs return to reset values with no fout_vld.

Source files
------------

// File: rtl/spcl_rdback.sv
// spcl_rdback: special-register read-back mux with port-pin synchronizers and a timed RF handshake.
// Define SPCL_CHG_DETECT_EN to build the per-port input-change flags (port_chg); otherwise they read 0.
module spcl_rdback #(
  parameter int SYNC_STAGES = 2,
  parameter int RF_TIMEOUT  = 15
) (
  input  logic       clk4,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [4:0] fsel,
  input  logic [7:0] fsr,
  input  logic [7:0] status,
  input  logic [7:0] tmr0,
  input  logic [7:0] pcl,
  input  logic [7:0] port_int_a,
  input  logic [7:0] port_int_b,
  input  logic [7:0] port_int_c,
  input  logic [7:0] trisa,
  input  logic [7:0] trisb,
  input  logic [7:0] trisc,
  input  logic [7:0] pin_a,
  input  logic [7:0] pin_b,
  input  logic [7:0] pin_c,
  output logic       rf_rd,
  output logic [4:0] rf_addr,
  input  logic [7:0] rf_data,
  input  logic       rf_ack,
  output logic       busy,
  output logic [7:0] fout,
  output logic       fout_vld,
  output logic       rd_err,
  output logic [2:0] port_chg
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RF_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [7:0] TMO_LAST   = 8'(RF_TIMEOUT - 1);

  logic [1:0]      state_reg;
  logic [7:0]      cnt_reg;
  logic [7:0]      data_reg;
  logic            err_reg;
  logic [2:0][7:0] pin_all, tris_all, latch_all, sync_all, port_val;
  logic [4:0]      eff;
  logic [7:0]      spcl_data;

  assign pin_all   = {pin_c, pin_b, pin_a};
  assign tris_all  = {trisc, trisb, trisa};
  assign latch_all = {port_int_c, port_int_b, port_int_a};

  // Input bits come from the synchronized pins, output bits from the latch.
  for (genvar gi = 0; gi < 3; gi++) begin : g_port
    logic [7:0] stage_reg [SYNC_STAGES];

    always_ff @(posedge clk4 or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < SYNC_STAGES; s++) stage_reg[s] <= 8'h00;
      end else begin
        stage_reg[0] <= pin_all[gi];
        for (int s = 1; s < SYNC_STAGES; s++) stage_reg[s] <= stage_reg[s-1];
      end
    end

    assign sync_all[gi] = stage_reg[SYNC_STAGES-1];
    assign port_val[gi] = (tris_all[gi] & sync_all[gi]) | (~tris_all[gi] & latch_all[gi]);
  end

  assign eff = (fsel == 5'd0) ? fsr[4:0] : fsel;

  always_comb begin
    spcl_data = 8'h00;
    case (eff)
      5'd1:    spcl_data = tmr0;
      5'd2:    spcl_data = pcl;
      5'd3:    spcl_data = status;
      5'd4:    spcl_data = fsr;
      5'd5:    spcl_data = port_val[0];
      5'd6:    spcl_data = port_val[1];
      5'd7:    spcl_data = port_val[2];
      default: spcl_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'h00;
      data_reg  <= 8'h00;
      err_reg   <= 1'b0;
      fout      <= 8'h00;
      fout_vld  <= 1'b0;
      rd_err    <= 1'b0;
      busy      <= 1'b0;
      rf_rd     <= 1'b0;
      rf_addr   <= 5'd0;
    end else begin
      fout_vld <= 1'b0;
      rd_err   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rd_req) begin
            busy     <= 1'b1;
            data_reg <= spcl_data;
            err_reg  <= 1'b0;
            if (eff < 5'd8) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_RF_WAIT;
              rf_rd     <= 1'b1;
              rf_addr   <= eff;
              cnt_reg   <= 8'h00;
            end
          end
        end
        ST_RF_WAIT: begin
          // An ack arriving on the timeout cycle still returns real data.
          if (rf_ack) begin
            data_reg  <= rf_data;
            err_reg   <= 1'b0;
            rf_rd     <= 1'b0;
            state_reg <= ST_DONE;
          end else if (cnt_reg == TMO_LAST) begin
            cnt_reg   <= cnt_reg + 8'd1;
            data_reg  <= 8'hFF;
            err_reg   <= 1'b1;
            rf_rd     <= 1'b0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_DONE: begin
          fout      <= data_reg;
          fout_vld  <= 1'b1;
          rd_err    <= err_reg;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef SPCL_CHG_DETECT_EN
  logic [2:0] port_sel;
  logic [2:0] sel_reg;

  assign port_sel = {eff == 5'd7, eff == 5'd6, eff == 5'd5};

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      sel_reg <= 3'b000;
    end else if (state_reg == ST_IDLE && rd_req) begin
      sel_reg <= port_sel;
    end
  end

  // A read of the port clears its flag; any live difference re-sets it against the new snapshot.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chg
    logic [7:0] snap_reg;
    logic       chg_reg;

    always_ff @(posedge clk4 or posedge reset) begin
      if (reset) begin
        snap_reg <= 8'h00;
        chg_reg  <= 1'b0;
      end else if (state_reg == ST_DONE && sel_reg[gi]) begin
        snap_reg <= data_reg;
        chg_reg  <= 1'b0;
      end else if (|((sync_all[gi] ^ snap_reg) & tris_all[gi])) begin
        chg_reg <= 1'b1;
      end
    end

    assign port_chg[gi] = chg_reg;
  end
`else
  assign port_chg = 3'b000;
`endif

endmodule

// File: tb/tb_spcl_rdback.sv
// tb_spcl_rdback: directed plus randomized reads of spcl_rdback against a transaction-level model.
// Change-flag expectations follow SPCL_CHG_DETECT_EN the same way the design does.
module tb_spcl_rdback;

  localparam int SYNC_STAGES = 2;
  localparam int RF_TIMEOUT  = 15;

  logic       clk4, reset, rd_req, rf_ack, rf_rd, busy, fout_vld, rd_err;
  logic [4:0] fsel, rf_addr;
  logic [7:0] fsr, status, tmr0, pcl, rf_data, fout;
  logic [7:0] port_int_a, port_int_b, port_int_c, trisa, trisb, trisc, pin_a, pin_b, pin_c;
  logic [2:0] port_chg;

  int total = 0;
  int bad   = 0;

  // Model: what each synchronizer holds once settled, each port's snapshot and sticky flag.
  logic [7:0] pin_m  [3];
  logic [7:0] snap_m [3];
  logic       chg_m  [3];

  spcl_rdback #(.SYNC_STAGES(SYNC_STAGES), .RF_TIMEOUT(RF_TIMEOUT)) dut (
    .clk4(clk4), .reset(reset), .rd_req(rd_req), .fsel(fsel), .fsr(fsr), .status(status),
    .tmr0(tmr0), .pcl(pcl), .port_int_a(port_int_a), .port_int_b(port_int_b),
    .port_int_c(port_int_c), .trisa(trisa), .trisb(trisb), .trisc(trisc),
    .pin_a(pin_a), .pin_b(pin_b), .pin_c(pin_c), .rf_rd(rf_rd), .rf_addr(rf_addr),
    .rf_data(rf_data), .rf_ack(rf_ack), .busy(busy), .fout(fout), .fout_vld(fout_vld),
    .rd_err(rd_err), .port_chg(port_chg)
  );

  initial begin
    clk4 = 1'b0;
    forever #5 clk4 = ~clk4;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk4);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("chk %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] chg_exp();
`ifdef SPCL_CHG_DETECT_EN
    return {chg_m[2], chg_m[1], chg_m[0]};
`else
    return 3'b000;
`endif
  endfunction

  function automatic logic [7:0] port_model(input logic [7:0] t, input logic [7:0] p,
                                            input logic [7:0] l);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = t[i] ? p[i] : l[i];
    return r;
  endfunction

  function automatic logic [7:0] read_model(input logic [4:0] e);
    case (e)
      5'd1:    return tmr0;
      5'd2:    return pcl;
      5'd3:    return status;
      5'd4:    return fsr;
      5'd5:    return port_model(trisa, pin_a, port_int_a);
      5'd6:    return port_model(trisb, pin_b, port_int_b);
      5'd7:    return port_model(trisc, pin_c, port_int_c);
      default: return 8'h00;
    endcase
  endfunction

  // A flag can be raised by the new tris against the old synced pins or against the new pins.
  task automatic drive_ports(input logic [7:0] pa, pb, pc, ta, tb, tc);
    logic [7:0] np [3];
    logic [7:0] nt [3];
    np[0] = pa; np[1] = pb; np[2] = pc;
    nt[0] = ta; nt[1] = tb; nt[2] = tc;
    for (int k = 0; k < 3; k++) begin
      if ((((pin_m[k] ^ snap_m[k]) & nt[k]) != 8'h00) ||
          (((np[k] ^ snap_m[k]) & nt[k]) != 8'h00))
        chg_m[k] = 1'b1;
      pin_m[k] = np[k];
    end
    pin_a = pa; pin_b = pb; pin_c = pc;
    trisa = ta; trisb = tb; trisc = tc;
  endtask

  task automatic set_ports(input logic [7:0] pa, pb, pc, ta, tb, tc);
    drive_ports(pa, pb, pc, ta, tb, tc);
    repeat (SYNC_STAGES + 1) tick;
    check("port_chg", port_chg, chg_exp());
  endtask

  // ack_at: RF_WAIT edge (1-based) at which rf_ack is presented; 0 = never.
  task automatic do_read(input logic [4:0] fs, input int ack_at, input bit poke);
    logic [4:0] e;
    logic [7:0] exp_d;
    logic       exp_e;
    int         waited, rd_hi, exp_hi;
    bit         done;
    e      = (fs == 5'd0) ? fsr[4:0] : fs;
    exp_d  = read_model(e);
    exp_e  = 1'b0;
    fsel   = fs;
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    check("busy_accept", busy, 1);
    check("vld_accept", fout_vld, 0);
    if (e >= 5'd8) begin
      check("rf_addr", rf_addr, e);
      exp_d  = 8'hFF;
      exp_e  = 1'b1;
      waited = 0;
      rd_hi  = 0;
      done   = 1'b0;
      while (!done) begin
        waited++;
        if (poke && waited == 2) rd_req = 1'b1;
        if (waited == ack_at) begin
          rf_data = 8'($urandom);
          rf_ack  = 1'b1;
          exp_d   = rf_data;
          exp_e   = 1'b0;
        end
        if (rf_rd) rd_hi++;
        tick;
        rd_req = 1'b0;
        rf_ack = 1'b0;
        done = (waited == ack_at) || (waited >= RF_TIMEOUT);
        if (!done) check("vld_in_wait", fout_vld, 0);
      end
      exp_hi = (ack_at == 0) ? RF_TIMEOUT : ack_at;
      check("rf_rd_cycles", rd_hi, exp_hi);
      check("rf_rd_drop", rf_rd, 0);
      check("busy_wait", busy, 1);
    end
    tick;
    check("fout_vld", fout_vld, 1);
    check("fout", fout, exp_d);
    check("rd_err", rd_err, exp_e);
    check("busy_done", busy, 0);
    $display("read fsel=%0h eff=%0h ack_at=%0d fout=%0h rd_err=%0b", fs, e, ack_at, fout, rd_err);
    if (e >= 5'd5 && e <= 5'd7) begin
      snap_m[e - 5'd5] = exp_d;
      chg_m[e - 5'd5]  = 1'b0;
    end
    tick;
    check("vld_pulse", fout_vld, 0);
    check("err_clear", rd_err, 0);
    check("fout_hold", fout, exp_d);
    tick;
    check("no_extra_vld", fout_vld, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_reset_vals(input string where);
    check({where, "_fout"}, fout, 0);
    check({where, "_vld"}, fout_vld, 0);
    check({where, "_busy"}, busy, 0);
    check({where, "_rf_rd"}, rf_rd, 0);
    check({where, "_rf_addr"}, rf_addr, 0);
    check({where, "_rd_err"}, rd_err, 0);
    check({where, "_chg"}, port_chg, 0);
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rf_ack = 1'b0; rf_data = 8'h00; fsel = 5'd0;
    fsr = 8'h00; status = 8'h00; tmr0 = 8'h00; pcl = 8'h00;
    port_int_a = 8'h00; port_int_b = 8'h00; port_int_c = 8'h00;
    trisa = 8'h00; trisb = 8'h00; trisc = 8'h00; pin_a = 8'h00; pin_b = 8'h00; pin_c = 8'h00;
    for (int k = 0; k < 3; k++) begin
      pin_m[k] = 8'h00; snap_m[k] = 8'h00; chg_m[k] = 1'b0;
    end
    tick; tick;
    check_reset_vals("rst");
    reset = 1'b0;
    tick;

    // STATUS read
    status = 8'h05;
    do_read(5'd3, 0, 1'b0);

    // Port A mixing latch and synced pins
    port_int_a = 8'hAA;
    set_ports(8'h3C, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00);
    do_read(5'd5, 0, 1'b0);
    check("porta_3a", fout, 8'h3A);

    // Indirect RF read, ack on the fourth RF_WAIT edge
    fsr = 8'h12;
    do_read(5'd0, 4, 1'b0);

    // Timeout with a request poked while busy
    do_read(5'd9, 0, 1'b1);

    // Ack exactly on the timeout edge, then INDF through fsr=0
    do_read(5'd20, RF_TIMEOUT, 1'b0);
    fsr = 8'h00;
    do_read(5'd0, 0, 1'b0);

    // Change detection on port B bit 2
    set_ports(pin_a, 8'h5A, pin_c, trisa, 8'hFF, trisc);
    do_read(5'd6, 0, 1'b0);
    check("chg_after_rd", port_chg, chg_exp());
    drive_ports(pin_a, 8'h5E, pin_c, trisa, 8'hFF, trisc);
    repeat (SYNC_STAGES) tick;
    check("chg_b_early", port_chg[1], 0);
    tick;
    check("chg_b_set", port_chg, chg_exp());
    do_read(5'd6, 0, 1'b0);
    check("chg_b_clear", port_chg[1], 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      set_ports(8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
      tmr0 = 8'($urandom); pcl = 8'($urandom); status = 8'($urandom); fsr = 8'($urandom);
      port_int_a = 8'($urandom); port_int_b = 8'($urandom); port_int_c = 8'($urandom);
      rf_ack = 1'b1;
      tick;
      rf_ack = 1'b0;
      check("stray_ack_vld", fout_vld, 0);
      do_read(5'($urandom), int'($urandom_range(0, RF_TIMEOUT)), n[0]);
      check("chg_rand", port_chg, chg_exp());
    end

    // Reset while waiting on the register file
    do_read(5'd5, 0, 1'b0);
    fsel   = 5'd17;
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    tick; tick; tick;
    check("pre_rst_rf_rd", rf_rd, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    tick;
    check("rst_hold_vld", fout_vld, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pin_m[k] = 8'h00; snap_m[k] = 8'h00; chg_m[k] = 1'b0;
    end
    for (int i = 0; i < RF_TIMEOUT + 3; i++) begin
      tick;
      check("post_rst_vld", fout_vld, 0);
    end
    check("post_rst_busy", busy, 0);
    set_ports(pin_a, pin_b, pin_c, trisa, trisb, trisc);
    do_read(5'd4, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
